cmdout_stream_arbiter: RTL and testbench

- Packet-atomic round-robin arbiter that merges per-accelerator finish-command streams into the single 64-bit stream consumed by the command-out engine.
- Tags every output beat with the source accelerator ID (TID).
- Holds a grant until the whole packet (header, task ID, parent task ID) has been forwarded, so packets from different accelerators never interleave.
- Sits between the accelerator finish ports and the command-out engine's input stream.

---
 rtl/cmdout_stream_arbiter.sv | 131 +++++++++++++
 tb/tb_cmdout_stream_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmdout_stream_arbiter.sv
// Packet-atomic round-robin merge of accelerator finish-command streams into one tagged 64-bit stream.
// Optional macro CMDOUT_ARB_LEN_CHECK_EN: fixed PKT_WORDS packet framing with sticky len_err.
module cmdout_stream_arbiter #(
    parameter int MAX_ACCS  = 16,
    parameter int ACC_BITS  = $clog2(MAX_ACCS),
    parameter int PKT_WORDS = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [64*MAX_ACCS-1:0]   acc_TDATA,
    input  logic [MAX_ACCS-1:0]      acc_TVALID,
    input  logic [MAX_ACCS-1:0]      acc_TLAST,
    output logic [MAX_ACCS-1:0]      acc_TREADY,
    output logic [63:0]              outStream_TDATA,
    output logic [ACC_BITS-1:0]      outStream_TID,
    output logic                     outStream_TLAST,
    output logic                     outStream_TVALID,
    input  logic                     outStream_TREADY,
    output logic                     len_err
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state;
    logic [ACC_BITS-1:0] rr_ptr;
    logic [ACC_BITS-1:0] grant;
    logic [ACC_BITS-1:0] pick;
    logic                pick_found;
    logic                take_ok;
    logic                accept;
    logic                is_last;

    logic [ACC_BITS-1:0] cand_idx [MAX_ACCS];
    logic [MAX_ACCS-1:0] cand_vld;

    // Candidate gi is the requester gi positions after rr_ptr, wrapped for non-power-of-two counts.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_ACCS; gi++) begin : g_cand
            assign cand_idx[gi] = (int'(rr_ptr) + gi >= MAX_ACCS)
                                ? ACC_BITS'(int'(rr_ptr) + gi - MAX_ACCS)
                                : ACC_BITS'(int'(rr_ptr) + gi);
            assign cand_vld[gi] = acc_TVALID[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        pick       = rr_ptr;
        pick_found = 1'b0;
        for (int k = MAX_ACCS - 1; k >= 0; k--) begin
            if (cand_vld[k]) begin
                pick       = cand_idx[k];
                pick_found = 1'b1;
            end
        end
    end

    assign take_ok = !outStream_TVALID || outStream_TREADY;

    always_comb begin
        acc_TREADY = '0;
        if (rstn && state == XFER) begin
            acc_TREADY[grant] = take_ok;
        end
    end

    assign accept = (state == XFER) && acc_TVALID[grant] && acc_TREADY[grant];

`ifdef CMDOUT_ARB_LEN_CHECK_EN
    localparam int CNT_W = $clog2(PKT_WORDS + 1);
    logic [CNT_W-1:0] beat_cnt;

    assign is_last = (beat_cnt == CNT_W'(PKT_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else if (accept) begin
            beat_cnt <= is_last ? '0 : beat_cnt + 1'b1;
            if (acc_TLAST[grant] != is_last) begin
                len_err <= 1'b1;
            end
        end
    end
`else
    assign is_last = acc_TLAST[grant];
    assign len_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            grant            <= '0;
            outStream_TVALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (accept && is_last) begin
                        state  <= IDLE;
                        rr_ptr <= (grant == ACC_BITS'(MAX_ACCS - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                outStream_TVALID <= 1'b1;
            end else if (outStream_TREADY) begin
                outStream_TVALID <= 1'b0;
            end
        end
    end

    // Payload registers carry no reset; they are only meaningful while outStream_TVALID is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            outStream_TDATA <= acc_TDATA[64*int'(grant) +: 64];
            outStream_TID   <= grant;
            outStream_TLAST <= is_last;
        end
    end

endmodule

// File: tb/tb_cmdout_stream_arbiter.sv
// Directed bench for cmdout_stream_arbiter: table of arbitration scenarios plus stall, reset and wrap sequences.
module tb_cmdout_stream_arbiter;

    localparam int N   = 16;
    localparam int AB  = 4;
    localparam int N5  = 5;
    localparam int AB5 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic [64*N-1:0]   acc_TDATA;
    logic [N-1:0]      acc_TVALID, acc_TLAST, acc_TREADY;
    logic [63:0]       outStream_TDATA;
    logic [AB-1:0]     outStream_TID;
    logic              outStream_TLAST, outStream_TVALID, outStream_TREADY, len_err;

    logic [64*N5-1:0]  a5_TDATA;
    logic [N5-1:0]     a5_TVALID, a5_TLAST, a5_TREADY;
    logic [63:0]       o5_TDATA;
    logic [AB5-1:0]    o5_TID;
    logic              o5_TLAST, o5_TVALID, o5_TREADY, len_err5;

    cmdout_stream_arbiter #(.MAX_ACCS(N)) u_dut (
        .clk(clk), .rstn(rstn),
        .acc_TDATA(acc_TDATA), .acc_TVALID(acc_TVALID), .acc_TLAST(acc_TLAST), .acc_TREADY(acc_TREADY),
        .outStream_TDATA(outStream_TDATA), .outStream_TID(outStream_TID), .outStream_TLAST(outStream_TLAST),
        .outStream_TVALID(outStream_TVALID), .outStream_TREADY(outStream_TREADY), .len_err(len_err)
    );

    cmdout_stream_arbiter #(.MAX_ACCS(N5)) u_dut5 (
        .clk(clk), .rstn(rstn),
        .acc_TDATA(a5_TDATA), .acc_TVALID(a5_TVALID), .acc_TLAST(a5_TLAST), .acc_TREADY(a5_TREADY),
        .outStream_TDATA(o5_TDATA), .outStream_TID(o5_TID), .outStream_TLAST(o5_TLAST),
        .outStream_TVALID(o5_TVALID), .outStream_TREADY(o5_TREADY), .len_err(len_err5)
    );

    typedef struct {
        int          tid;
        logic [63:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        bit          rst;
        logic [N-1:0] mask;
        int          n;
        int          tid [3];
    } vec_t;

    beat_t       outq [$];
    int          tid5q [$];
    logic [64:0] srcq  [N][$];
    logic [64:0] src5q [N5][$];
    int          cyc;
    int          checks;
    int          errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input int src, input int base, input int k);
        return (64'(src) << 56) | 64'(base + k);
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            acc_TVALID[i]        = (srcq[i].size() > 0);
            acc_TDATA[64*i +: 64] = acc_TVALID[i] ? srcq[i][0][63:0] : 64'h0;
            acc_TLAST[i]         = acc_TVALID[i] ? srcq[i][0][64] : 1'b0;
        end
        for (int i = 0; i < N5; i++) begin
            a5_TVALID[i]         = (src5q[i].size() > 0);
            a5_TDATA[64*i +: 64] = a5_TVALID[i] ? src5q[i][0][63:0] : 64'h0;
            a5_TLAST[i]          = a5_TVALID[i] ? src5q[i][0][64] : 1'b0;
        end
    endtask

    // One clock: handshakes are sampled just before the edge, queues updated just after it.
    task automatic step();
        logic [N-1:0]  f;
        logic [N5-1:0] f5;
        logic          of, of5;
        int            t5;
        beat_t         b;
        #1;
        drive();
        #1;
        f   = acc_TVALID & acc_TREADY;
        f5  = a5_TVALID & a5_TREADY;
        of  = outStream_TVALID & outStream_TREADY;
        of5 = o5_TVALID & o5_TREADY;
        b   = '{int'(outStream_TID), outStream_TDATA, outStream_TLAST, cyc};
        t5  = int'(o5_TID);
        @(posedge clk);
        #1;
        cyc++;
        if (of)  outq.push_back(b);
        if (of5) tid5q.push_back(t5);
        for (int i = 0; i < N; i++)  if (f[i])  void'(srcq[i].pop_front());
        for (int i = 0; i < N5; i++) if (f5[i]) void'(src5q[i].pop_front());
        drive();
    endtask

    task automatic push_pkt(input int src, input int base, input logic [2:0] lastmask);
        for (int k = 0; k < 3; k++) srcq[src].push_back({lastmask[k], beat_data(src, base, k)});
    endtask

    task automatic push_pkt5(input int src);
        for (int k = 0; k < 3; k++) src5q[src].push_back({(k == 2), beat_data(src, 8'h50, k)});
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        outq.delete();
        tid5q.delete();
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        for (int i = 0; i < budget && outq.size() < n; i++) step();
        checks++;
        if (outq.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats, expected %0d", name, outq.size(), n);
        end
    endtask

    vec_t vecs [5];

    initial begin
        int c0;
        int exp5 [4];
        checks = 0;
        errors = 0;
        cyc    = 0;
        rstn   = 1'b0;
        outStream_TREADY = 1'b1;
        o5_TREADY        = 1'b1;
        drive();

        vecs[0] = '{1'b1, 16'h0020, 1, '{5, 0, 0}};
        vecs[1] = '{1'b0, 16'h0050, 2, '{6, 4, 0}};
        vecs[2] = '{1'b0, 16'h0030, 2, '{5, 4, 0}};
        vecs[3] = '{1'b1, 16'h8009, 3, '{0, 3, 15}};
        vecs[4] = '{1'b0, 16'h8001, 2, '{0, 15, 0}};

        @(posedge clk);
        #1;
        do_reset();
        check("rst_out_valid", 64'(outStream_TVALID), 0);
        check("rst_acc_ready", 64'(acc_TREADY), 0);
        check("rst_len_err", 64'(len_err), 0);

        // Wrap on a 5-input instance: rr_ptr is brought to 4 by serving acc 3 first.
        push_pkt5(3);
        for (int i = 0; i < 40 && tid5q.size() < 3; i++) step();
        check("wrap_warmup_beats", 64'(tid5q.size()), 3);
        tid5q.delete();
        push_pkt5(4); push_pkt5(4); push_pkt5(0); push_pkt5(0);
        for (int i = 0; i < 80 && tid5q.size() < 12; i++) step();
        check("wrap_beats", 64'(tid5q.size()), 12);
        exp5 = '{4, 0, 4, 0};
        for (int i = 0; i < 12 && i < tid5q.size(); i++) begin
            check($sformatf("wrap_tid[%0d]", i), 64'(tid5q[i]), 64'(exp5[i/3]));
            $display("wrap beat %0d: tid=%0d", i, tid5q[i]);
        end

        // Table of arbitration scenarios: each source sends one 3-beat packet.
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].rst) do_reset();
            outq.delete();
            c0 = cyc;
            for (int i = 0; i < N; i++) if (vecs[v].mask[i]) push_pkt(i, 8'h0A, 3'b100);
            run_until(3 * vecs[v].n, 60, $sformatf("vec%0d", v));
            for (int s = 0; s < 4; s++) step();
            check($sformatf("vec%0d_count", v), 64'(outq.size()), 64'(3 * vecs[v].n));
            for (int p = 0; p < vecs[v].n; p++) begin
                for (int k = 0; k < 3; k++) begin
                    if (p * 3 + k < outq.size()) begin
                        beat_t b;
                        b = outq[p*3+k];
                        $display("vec%0d beat %0d: tid=%0d data=%h last=%0d cyc=%0d",
                                 v, p*3+k, b.tid, b.data, b.last, b.cyc - c0);
                        check($sformatf("vec%0d_tid[%0d]", v, p*3+k), 64'(b.tid), 64'(vecs[v].tid[p]));
                        check($sformatf("vec%0d_data[%0d]", v, p*3+k), b.data,
                              beat_data(vecs[v].tid[p], 8'h0A, k));
                        check($sformatf("vec%0d_last[%0d]", v, p*3+k), 64'(b.last), 64'(k == 2));
                        check($sformatf("vec%0d_cyc[%0d]", v, p*3+k), 64'(b.cyc - c0), 64'(2 + 4*p + k));
                    end
                end
            end
        end

        // Downstream stall while the middle beat sits in the output register.
        do_reset();
        push_pkt(2, 8'h20, 3'b100);
        step(); step(); step();
        outStream_TREADY = 1'b0;
        for (int s = 0; s < 4; s++) begin
            step();
            $display("stall cycle %0d: valid=%0d tid=%0d data=%h", s, outStream_TVALID, outStream_TID, outStream_TDATA);
            check($sformatf("stall_valid[%0d]", s), 64'(outStream_TVALID), 1);
            check($sformatf("stall_data[%0d]", s), outStream_TDATA, beat_data(2, 8'h20, 1));
            check($sformatf("stall_tid[%0d]", s), 64'(outStream_TID), 2);
            check($sformatf("stall_ready[%0d]", s), 64'(acc_TREADY), 0);
        end
        outStream_TREADY = 1'b1;
        run_until(3, 30, "stall");
        for (int s = 0; s < 4; s++) step();
        check("stall_count", 64'(outq.size()), 3);
        for (int k = 0; k < 3 && k < outq.size(); k++) begin
            check($sformatf("stall_seq[%0d]", k), outq[k].data, beat_data(2, 8'h20, k));
            check($sformatf("stall_seq_last[%0d]", k), 64'(outq[k].last), 64'(k == 2));
        end

        // Reset mid-packet: rr_ptr would be 10 without reset, so acc 0 must beat acc 12 afterwards.
        do_reset();
        push_pkt(9, 8'h90, 3'b100);
        run_until(3, 30, "pre_rst");
        outq.delete();
        push_pkt(9, 8'h98, 3'b100);
        for (int i = 0; i < 30 && outq.size() < 1; i++) step();
        rstn = 1'b0;
        step();
        $display("mid-packet reset: valid=%0d ready=%h", outStream_TVALID, acc_TREADY);
        check("midrst_valid", 64'(outStream_TVALID), 0);
        check("midrst_ready", 64'(acc_TREADY), 0);
        rstn = 1'b1;
        srcq[9].delete();
        outq.delete();
        push_pkt(12, 8'hC0, 3'b100);
        push_pkt(0, 8'h00, 3'b100);
        run_until(6, 60, "postrst");
        for (int k = 0; k < 6 && k < outq.size(); k++) begin
            $display("post-reset beat %0d: tid=%0d data=%h last=%0d", k, outq[k].tid, outq[k].data, outq[k].last);
            check($sformatf("postrst_tid[%0d]", k), 64'(outq[k].tid), (k < 3) ? 64'd0 : 64'd12);
            check($sformatf("postrst_data[%0d]", k), outq[k].data,
                  (k < 3) ? beat_data(0, 8'h00, k) : beat_data(12, 8'hC0, k - 3));
        end

`ifdef CMDOUT_ARB_LEN_CHECK_EN
        // Early TLAST on beat 2: framing still three beats, error latched until reset.
        do_reset();
        push_pkt(2, 8'h40, 3'b010);
        run_until(3, 30, "lenchk");
        for (int k = 0; k < 3 && k < outq.size(); k++) begin
            $display("lenchk beat %0d: tid=%0d data=%h last=%0d", k, outq[k].tid, outq[k].data, outq[k].last);
            check($sformatf("lenchk_last[%0d]", k), 64'(outq[k].last), 64'(k == 2));
            check($sformatf("lenchk_data[%0d]", k), outq[k].data, beat_data(2, 8'h40, k));
        end
        check("lenchk_err", 64'(len_err), 1);
        step(); step(); step();
        check("lenchk_err_sticky", 64'(len_err), 1);
        do_reset();
        check("lenchk_err_cleared", 64'(len_err), 0);
`else
        check("len_err_tied", 64'(len_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
